seg7_capture: RTL



---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_capture_if.sv | 29 ++
 rtl/seg7_classify.sv | 33 +++
 rtl/seg7_capture.sv | 132 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: lit-high segment table {a,b,c,d,e,f,g},
// capture FSM states and the classification of an accepted pattern.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_DIGIT,
    CLS_BLANK,
    CLS_ILLEGAL
  } seg_class_t;

  typedef enum logic {
    ST_SETTLE,
    ST_LOCKED
  } capture_state_t;

endpackage

// File: rtl/seg7_capture_if.sv
// Bundle of the active-low segment pins and the decoded read-back outputs.
interface seg7_capture_if;

  logic led_a;
  logic led_b;
  logic led_c;
  logic led_d;
  logic led_e;
  logic led_f;
  logic led_g;
  logic B;
  logic C;
  logic D;
  logic valid;
  logic blank;
  logic err;
  logic locked;

  modport master (
    output led_a, led_b, led_c, led_d, led_e, led_f, led_g,
    input  B, C, D, valid, blank, err, locked
  );

  modport slave (
    input  led_a, led_b, led_c, led_d, led_e, led_f, led_g,
    output B, C, D, valid, blank, err, locked
  );

endinterface

// File: rtl/seg7_classify.sv
// Inverse of the 7-segment decoder: maps a lit-high pattern to its digit,
// or flags it as blank; anything else is neither.
module seg7_classify
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [2:0] value,
  output logic       is_digit,
  output logic       is_blank
);

  always_comb begin
    value    = 3'd0;
    is_digit = 1'b1;
    is_blank = 1'b0;
    case (pattern)
      SEG_0: value = 3'd0;
      SEG_1: value = 3'd1;
      SEG_2: value = 3'd2;
      SEG_3: value = 3'd3;
      SEG_4: value = 3'd4;
      SEG_5: value = 3'd5;
      SEG_6: value = 3'd6;
      SEG_7: value = 3'd7;
      SEG_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default: is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Reads a digit back from active-low 7-segment pins: synchronizes, waits for
// STABLE_CYCLES identical samples, then classifies and reports changes.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic           clk,
  input  logic           rst,
  seg7_capture_if.slave  bus
);

  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);

  logic [6:0]       pins;
  logic [6:0]       sync1;
  logic [6:0]       sync2;
  logic [6:0]       seg_s;
  logic [6:0]       cand;
  logic [6:0]       pattern;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  capture_state_t   state;
  seg_class_t       cls;
  seg_class_t       new_cls;
  logic [2:0]       value;
  logic [2:0]       value_r;
  logic             is_digit;
  logic             is_blank;
  logic             accept;
  logic             changed;
  logic             valid_r;
  logic             blank_r;
  logic             err_r;
  logic             locked_r;

  assign pins  = {bus.led_a, bus.led_b, bus.led_c, bus.led_d,
                  bus.led_e, bus.led_f, bus.led_g};
  assign seg_s = ~sync2;

  // With a single-sample requirement the pattern is accepted on the same edge
  // it is captured, so it must be classified before it lands in cand.
  assign pattern = (STABLE_CYCLES == 1) ? seg_s : cand;

  seg7_classify u_classify (
    .pattern  (pattern),
    .value    (value),
    .is_digit (is_digit),
    .is_blank (is_blank)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 7'h7F;
      sync2 <= 7'h7F;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
    end
  end

  always_comb begin
    cnt_inc = cnt + CNT_W'(1);
    if (is_digit)
      new_cls = CLS_DIGIT;
    else if (is_blank)
      new_cls = CLS_BLANK;
    else
      new_cls = CLS_ILLEGAL;
    changed = (new_cls != cls) || ((new_cls == CLS_DIGIT) && (value != value_r));
    if (seg_s != cand)
      accept = (STABLE_CYCLES == 1);
    else
      accept = (state == ST_SETTLE) && (cnt_inc == STABLE_N);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand     <= SEG_BLANK;
      cnt      <= '0;
      state    <= ST_SETTLE;
      cls      <= CLS_NONE;
      value_r  <= 3'd0;
      valid_r  <= 1'b0;
      blank_r  <= 1'b0;
      err_r    <= 1'b0;
      locked_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (seg_s != cand) begin
        cand     <= seg_s;
        cnt      <= CNT_W'(1);
        state    <= ST_SETTLE;
        locked_r <= 1'b0;
      end else if (state == ST_SETTLE) begin
        cnt <= cnt_inc;
      end
      // Blank and illegal keep the last good digit on B/C/D.
      if (accept) begin
        state    <= ST_LOCKED;
        locked_r <= 1'b1;
        cls      <= new_cls;
        valid_r  <= changed;
        case (new_cls)
          CLS_DIGIT: begin
            value_r <= value;
            blank_r <= 1'b0;
            err_r   <= 1'b0;
          end
          CLS_BLANK: begin
            blank_r <= 1'b1;
            err_r   <= 1'b0;
          end
          default: begin
            blank_r <= 1'b0;
            err_r   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.B      = value_r[2];
  assign bus.C      = value_r[1];
  assign bus.D      = value_r[0];
  assign bus.valid  = valid_r;
  assign bus.blank  = blank_r;
  assign bus.err    = err_r;
  assign bus.locked = locked_r;

endmodule
